axi_write_slave: RTL and testbench
==================================

Name: axi_write_slave

Overview:
- AXI4 write-channel slave that consumes the AW/W/B traffic produced by the write-channel master (FSM and ILA model pair).
- Accepts one burst at a time, generates a per-beat address, and drives a simple SRAM-style write port.
- Returns BRESP OKAY or SLVERR.
- Serves as the downstream responder for the write-channel master in block and formal benches.

Parameters:
- AW, 32, address width.
- DW, 64, write data width; strobe width is DW/8.

Ports:
- axi_aclk  in  1  clock, rising edge.
- axi_aresetn  in  1  asynchronous active-low reset.
- axi_awaddr  in  AW  burst start address.
- axi_awlen  in  8  beats minus one.
- axi_awsize  in  3  log2 bytes per beat.
- axi_awburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- axi_awvalid  in  1  address valid.
- axi_awready  out  1  address accepted.
- axi_wdata  in  DW  beat data.
- axi_wstrb  in  DW/8  byte strobes.
- axi_wlast  in  1  final beat marker.
- axi_wvalid  in  1  data valid.
- axi_wready  out  1  data accepted.
- axi_bresp  out  2  0 OKAY, 2 SLVERR.
- axi_bvalid  out  1  response valid.
- axi_bready  in  1  master accepts response.
- mem_we  out  1  one-cycle write pulse.
- mem_addr  out  AW  beat byte address.
- mem_wdata  out  DW  beat data.
- mem_wstrb  out  DW/8  beat strobes; forced to 0 when the burst is in error.

Behaviour:
- Clocking and reset: single clock, axi_aclk. axi_aresetn is asynchronous and active-low.
- Reset values: all outputs are registered and reset to 0, bresp included. The FSM resets to INIT.
- INIT -> IDLE unconditionally on the first clock after reset release. axi_awready asserts in that same transition.
- IDLE: awready=1.
  - On awvalid&awready, latch awaddr/awlen/awsize/awburst, clear beat_cnt, and evaluate err.
  - err = (awburst==3) | (awsize > log2(DW/8)) | (awburst==WRAP & awlen not in {1,3,7,15}).
  - Next state DATA: awready drops and wready rises on the same edge.
- DATA: wready=1. On each W handshake:
  - mem_we pulses on the next cycle, with mem_addr=cur_addr and mem_wdata/mem_wstrb registered from the beat; write latency is 1 cycle.
  - If err is set, mem_we still pulses with mem_wstrb=0, so no bytes are written.
  - Burst termination: the burst ends on the beat where beat_cnt==len OR wlast=1, whichever comes first.
  - wlast mismatch: if wlast differs from (beat_cnt==len), set err.
  - On termination, wready drops and the FSM goes to RESP with bvalid=1 and bresp=err?2:0.
- Address arithmetic: step = 1<<size.
  - FIXED: cur_addr is constant.
  - INCR: beat 0 uses the unaligned awaddr. Each later beat uses (aligned previous address)+step, modulo 2^AW. There is no 4 KB boundary check.
  - WRAP: wrap_bytes = (len+1)*step and lower = awaddr & ~(wrap_bytes-1). The next address is cur+step; if next >= lower+wrap_bytes it becomes lower.
- RESP: bvalid and bresp are held stable until bready. On handshake, bvalid drops and awready rises on the same edge (FSM -> IDLE), so back-to-back bursts have 1 idle cycle minimum.
- No outstanding bursts: awvalid is ignored outside IDLE. W beats arriving before the AW handshake are stalled with wready=0.
- Reset mid-burst: FSM returns to INIT immediately and all outputs are 0. A partially written burst is abandoned and no B response is issued.

Decomposition:
- Package axi_pkg holds:
  - burst encodings BURST_FIXED/INCR/WRAP;
  - RESP_OKAY/RESP_SLVERR;
  - the state enum INIT/IDLE/DATA/RESP.
- Sub-module axi_burst_addr_gen: combinational next-address logic from (cur_addr, awaddr, len, size, burst). The same logic is reusable for a future read slave.

Test Plan:
- INCR single beat: awaddr=0x100, len=0, size=3, data=0xA5A5_A5A5_A5A5_A5A5, strb=0xFF, wlast=1 -> one mem_we with mem_addr=0x100; bresp=0, bvalid until bready.
- INCR 4 beats, unaligned: awaddr=0x1003, size=3 -> mem_addr sequence 0x1003, 0x1008, 0x1010, 0x1018; bresp=OKAY.
- WRAP 4 beats: awaddr=0x38, size=3, len=3 -> mem_addr 0x38, 0x20, 0x28, 0x30.
- Error cases:
  - awburst=3, len=1 -> two mem_we pulses with wstrb=0; bresp=2.
  - WRAP with len=2 -> bresp=2.
- Early wlast: len=3, wlast on beat 1 -> two writes, then bresp=2. Wrong final marker: wlast=0 on beat 3 -> 4 writes, then bresp=2.
- Response backpressure and reset:
  - bready held low 5 cycles -> bvalid/bresp stable and awready=0 throughout.
  - axi_aresetn pulsed low mid-DATA -> all outputs 0 asynchronously; awready returns 1 cycle after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state type and small helpers for the write slave.
package axi_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'd0;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'd1;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'd2;
  localparam logic [BURST_W-1:0] BURST_RSVD  = 2'd3;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'd0;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0]      cur_addr,
  input  logic [AW-1:0]      start_addr,
  input  logic [LEN_W-1:0]   len,
  input  logic [SIZE_W-1:0]  size,
  input  logic [BURST_W-1:0] burst,
  output logic [AW-1:0]      next_addr_c
);

  logic [AW-1:0] step;
  logic [AW-1:0] wrap_bytes;
  logic [AW-1:0] lower;
  logic [AW-1:0] incr_next;

  // Step to the following beat; WRAP folds back to the aligned window base.
  always_comb begin
    step        = AW'(1) << size;
    wrap_bytes  = (AW'(len) + AW'(1)) << size;
    lower       = start_addr & ~(wrap_bytes - AW'(1));
    incr_next   = cur_addr + step;
    next_addr_c = cur_addr;
    case (burst)
      BURST_FIXED: next_addr_c = cur_addr;
      BURST_WRAP:  next_addr_c = (incr_next >= (lower + wrap_bytes)) ? lower : incr_next;
      default:     next_addr_c = (cur_addr & ~(step - AW'(1))) + step;
    endcase
  end

endmodule

// File: rtl/axi_write_slave.sv
// AXI4 write slave: one burst at a time, per-beat SRAM write port, OKAY/SLVERR response.
module axi_write_slave
  import axi_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [AW-1:0]       axi_awaddr,
  input  logic [LEN_W-1:0]    axi_awlen,
  input  logic [SIZE_W-1:0]   axi_awsize,
  input  logic [BURST_W-1:0]  axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DW-1:0]       axi_wdata,
  input  logic [DW/8-1:0]     axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [RESP_W-1:0]   axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [DW/8-1:0]     mem_wstrb
);

  localparam int unsigned SW       = DW / 8;
  localparam int unsigned SIZE_MAX = $clog2(SW);

  wr_state_e            state;
  logic [AW-1:0]        start_addr;
  logic [AW-1:0]        cur_addr;
  logic [LEN_W-1:0]     len_q;
  logic [SIZE_W-1:0]    size_q;
  logic [BURST_W-1:0]   burst_q;
  logic [LEN_W-1:0]     beat_cnt;
  logic                 err;

  logic [AW-1:0]        next_addr_c;
  logic                 beat_last_c;
  logic                 aw_err_c;
  logic                 last_mismatch_c;

  axi_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .cur_addr    (cur_addr),
    .start_addr  (start_addr),
    .len         (len_q),
    .size        (size_q),
    .burst       (burst_q),
    .next_addr_c (next_addr_c)
  );

  // Burst legality at AW time and per-beat termination/marker checks.
  always_comb begin
    aw_err_c        = (axi_awburst == BURST_RSVD)
                    | (axi_awsize > SIZE_W'(SIZE_MAX))
                    | ((axi_awburst == BURST_WRAP) & ~wrap_len_ok(axi_awlen));
    beat_last_c     = (beat_cnt == len_q);
    last_mismatch_c = (axi_wlast != beat_last_c);
  end

  // Control FSM with all channel and memory-port outputs registered.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state       <= INIT;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      start_addr  <= '0;
      cur_addr    <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        INIT: begin
          axi_awready <= 1'b1;
          state       <= IDLE;
        end
        IDLE: begin
          if (axi_awvalid && axi_awready) begin
            start_addr  <= axi_awaddr;
            cur_addr    <= axi_awaddr;
            len_q       <= axi_awlen;
            size_q      <= axi_awsize;
            burst_q     <= axi_awburst;
            beat_cnt    <= '0;
            err         <= aw_err_c;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (axi_wvalid && axi_wready) begin
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= axi_wdata;
            mem_wstrb <= err ? '0 : axi_wstrb;
            beat_cnt  <= beat_cnt + LEN_W'(1);
            cur_addr  <= next_addr_c;
            if (last_mismatch_c) begin
              err <= 1'b1;
            end
            if (beat_last_c || axi_wlast) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= (err || last_mismatch_c) ? RESP_SLVERR : RESP_OKAY;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (axi_bvalid && axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_bresp   <= RESP_OKAY;
            axi_awready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_slave.sv
// Randomized self-checking bench for axi_write_slave against a closed-form burst model.
module tb_axi_write_slave;
  import axi_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [SW-1:0] obs_strb[$];

  always #5 clk = ~clk;

  axi_write_slave #(.AW(AW), .DW(DW)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .axi_awaddr  (awaddr),
    .axi_awlen   (awlen),
    .axi_awsize  (awsize),
    .axi_awburst (awburst),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wlast   (wlast),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_bresp   (bresp),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Collect every memory write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      obs_strb.push_back(mem_wstrb);
    end
  end

  function automatic bit model_aw_err(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    return (burst == 2'd3) || (size > 3'd3) ||
           (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Closed-form address of beat i.
  function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
    logic [31:0] step;
    logic [31:0] wb;
    logic [31:0] lower;
    step = 32'd1 << size;
    if (burst == 2'd0) return addr;
    if (burst == 2'd2) begin
      wb    = (32'(len) + 32'd1) * step;
      lower = addr & ~(wb - 32'd1);
      return lower + (((addr - lower) + 32'(i) * step) % wb);
    end
    if (i == 0) return addr;
    return (addr & ~(step - 32'd1)) + 32'(i) * step;
  endfunction

  // mode 0: correct wlast, 1: wlast early on beat k, 2: wlast never asserted.
  task automatic run_burst(input string name, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input int k, input int bdelay, input int gap_pct,
                           input bit use_fix, input logic [63:0] dfix);
    logic [63:0] d[$];
    logic [7:0]  s[$];
    int          nbeats;
    int          cnt;
    bit          aw_err;
    bit          exp_err;
    bit          addr_ok;
    logic [1:0]  held;

    aw_err  = model_aw_err(len, size, burst);
    nbeats  = (mode == 1) ? k + 1 : int'(len) + 1;
    exp_err = aw_err || (mode != 0);
    addr_ok = (burst != 2'd3) && !(burst == 2'd2 && aw_err && size <= 3'd3);
    obs_addr.delete();
    obs_data.delete();
    obs_strb.delete();

    @(negedge clk);
    awaddr  = addr;
    awlen   = len;
    awsize  = size;
    awburst = burst;
    awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!awready) begin
      check({name, ".aw_timeout"}, 64'(awready), 64'd1);
      awvalid = 1'b0;
      return;
    end
    @(negedge clk);
    awvalid = 1'b0;
    check({name, ".awready_drop"}, 64'(awready), 64'd0);
    check({name, ".wready_rise"}, 64'(wready), 64'd1);

    for (int i = 0; i < nbeats; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      wdata  = use_fix ? dfix : {$urandom, $urandom};
      wstrb  = use_fix ? 8'hFF : 8'($urandom);
      wlast  = (mode == 1) ? (i == k) : (mode == 2) ? 1'b0 : (i == int'(len));
      wvalid = 1'b1;
      d.push_back(wdata);
      s.push_back(wstrb);
      cnt = 0;
      while (!wready && cnt < 50) begin
        @(negedge clk);
        cnt++;
      end
      if (!wready) begin
        check({name, ".w_timeout"}, 64'(wready), 64'd1);
        wvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;

    check({name, ".bvalid"}, 64'(bvalid), 64'd1);
    check({name, ".bresp"}, 64'(bresp), exp_err ? 64'd2 : 64'd0);
    check({name, ".wready_drop"}, 64'(wready), 64'd0);
    held = exp_err ? 2'd2 : 2'd0;
    for (int j = 0; j < bdelay; j++) begin
      @(negedge clk);
      check({name, ".bp_bvalid"}, 64'(bvalid), 64'd1);
      check({name, ".bp_bresp"}, 64'(bresp), 64'(held));
      check({name, ".bp_awready"}, 64'(awready), 64'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check({name, ".bvalid_drop"}, 64'(bvalid), 64'd0);
    check({name, ".awready_back"}, 64'(awready), 64'd1);

    check({name, ".nwrites"}, 64'(obs_addr.size()), 64'(nbeats));
    for (int i = 0; i < nbeats && i < obs_addr.size(); i++) begin
      if (addr_ok)
        check({name, ".addr"}, 64'(obs_addr[i]), 64'(model_addr(addr, len, size, burst, i)));
      check({name, ".data"}, obs_data[i], d[i]);
      check({name, ".strb"}, 64'(obs_strb[i]), aw_err ? 64'd0 : 64'(s[i]));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".awready"}, 64'(awready), 64'd0);
    check({name, ".wready"}, 64'(wready), 64'd0);
    check({name, ".bvalid"}, 64'(bvalid), 64'd0);
    check({name, ".bresp"}, 64'(bresp), 64'd0);
    check({name, ".mem_we"}, 64'(mem_we), 64'd0);
    check({name, ".mem_addr"}, 64'(mem_addr), 64'd0);
    check({name, ".mem_wdata"}, mem_wdata, 64'd0);
    check({name, ".mem_wstrb"}, 64'(mem_wstrb), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  sz;
    logic [1:0]  b;
    int          mode;
    int          k;
    int          cnt;

    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("init_awready", 64'(awready), 64'd0);
    @(negedge clk);
    check("idle_awready", 64'(awready), 64'd1);

    // W beat ahead of AW must be stalled.
    wvalid = 1'b1;
    wdata  = 64'h1234;
    wstrb  = 8'hFF;
    wlast  = 1'b1;
    @(negedge clk);
    check("early_w_stall", 64'(wready), 64'd0);
    @(negedge clk);
    check("early_w_nowrite", 64'(obs_addr.size()), 64'd0);
    wvalid = 1'b0;
    wlast  = 1'b0;

    run_burst("incr1", 32'h100, 8'd0, 3'd3, 2'd1, 0, 0, 5, 0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
    run_burst("incr4u", 32'h1003, 8'd3, 3'd3, 2'd1, 0, 0, 0, 0, 1'b0, 64'd0);
    if (obs_addr.size() == 4) begin
      check("incr4u.a1", 64'(obs_addr[1]), 64'h1008);
      check("incr4u.a3", 64'(obs_addr[3]), 64'h1018);
    end
    run_burst("wrap4", 32'h38, 8'd3, 3'd3, 2'd2, 0, 0, 1, 0, 1'b0, 64'd0);
    if (obs_addr.size() == 4) begin
      check("wrap4.a1", 64'(obs_addr[1]), 64'h20);
      check("wrap4.a3", 64'(obs_addr[3]), 64'h30);
    end
    run_burst("rsvd", 32'h200, 8'd1, 3'd3, 2'd3, 0, 0, 0, 0, 1'b0, 64'd0);
    run_burst("wrap3", 32'h40, 8'd2, 3'd3, 2'd2, 0, 0, 0, 0, 1'b0, 64'd0);
    run_burst("early_last", 32'h300, 8'd3, 3'd3, 2'd1, 1, 1, 0, 0, 1'b0, 64'd0);
    run_burst("no_last", 32'h400, 8'd3, 3'd3, 2'd1, 2, 0, 0, 0, 1'b0, 64'd0);
    run_burst("fixed", 32'h505, 8'd3, 3'd2, 2'd0, 0, 0, 0, 30, 1'b0, 64'd0);
    run_burst("big_size", 32'h600, 8'd1, 3'd4, 2'd1, 0, 0, 2, 0, 1'b0, 64'd0);

    // Reset pulsed in the middle of a data phase.
    @(negedge clk);
    awaddr = 32'h800; awlen = 8'd7; awsize = 3'd3; awburst = 2'd1; awvalid = 1'b1;
    cnt = 0;
    while (!awready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 64'hDEAD_BEEF_0000_0001; wstrb = 8'h0F; wlast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_we_before_rst", 64'(mem_we), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rel_awready", 64'(awready), 64'd0);
    @(negedge clk);
    check("mid_rel_awready1", 64'(awready), 64'd1);
    check("mid_rel_bvalid", 64'(bvalid), 64'd0);

    for (int n = 0; n < 60; n++) begin
      b  = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      sz = 3'($urandom_range(0, 19) == 0 ? 4 : $urandom_range(0, 3));
      if (b == 2'd2) begin
        l = ($urandom_range(0, 7) == 0) ? 8'd2 : 8'((1 << $urandom_range(1, 4)) - 1);
      end else begin
        l = 8'($urandom_range(0, 15));
      end
      a = $urandom;
      if (b == 2'd2) a = a & ~((32'd1 << sz) - 32'd1);
      mode = 0;
      k    = 0;
      if ($urandom_range(0, 9) == 0) mode = 2;
      else if (l > 0 && $urandom_range(0, 9) == 0) begin
        mode = 1;
        k    = $urandom_range(0, int'(l) - 1);
      end
      run_burst("rand", a, l, sz, b, mode, k, $urandom_range(0, 3), 20, 1'b0, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
